ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter: the send side of the keyboard port, alongside the existing PS/2 receive/decode path.
- Sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xFF reset) using the standard PS/2 host request-to-send sequence, then checks the device ACK.
- Drives both PS/2 lines through open-drain enables. Exposes a load/busy/done handshake to the CPU side.

---
 rtl/ps2_host_tx.sv | 198 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : ps2_host_tx
//  Purpose  : PS/2 host-to-device command transmitter with ACK check.
//  Revision : 1.0
// ============================================================================
module ps2_host_tx #(
   parameter int counterBits   = 16,
   parameter int inhibitCycles = 400,
   parameter int rtsCycles     = 4,
   parameter int timeoutCycles = 60000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] data,
   input  logic       load,
   input  logic       ps2ClkIn,
   input  logic       ps2DataIn,
   output logic       ps2ClkDriveLow,
   output logic       ps2DataDriveLow,
   output logic       busy,
   output logic       done,
   output logic       ackOk,
   output logic       error
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_INHIBIT   = 3'd1,
      ST_RTS       = 3'd2,
      ST_SEND      = 3'd3,
      ST_WAIT_ACK  = 3'd4,
      ST_WAIT_IDLE = 3'd5
   } state_t;

   localparam logic [counterBits-1:0] c_inhibit_last = counterBits'(inhibitCycles - 1);
   localparam logic [counterBits-1:0] c_rts_last     = counterBits'(rtsCycles - 1);
   localparam logic [counterBits-1:0] c_timeout_last = counterBits'(timeoutCycles - 1);

   state_t                 state_q, state_d;
   logic [counterBits-1:0] counter_q, counter_d;
   logic [3:0]             bit_count_q, bit_count_d;
   logic [9:0]             shift_q, shift_d;
   logic                   clk_drive_q, clk_drive_d;
   logic                   data_drive_q, data_drive_d;
   logic                   done_q, done_d;
   logic                   ack_ok_q, ack_ok_d;
   logic                   error_q, error_d;
   logic                   clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_prev_q, clk_prev_d;
   logic                   data_s1_q, data_s1_d, data_s2_q, data_s2_d;
   logic                   w_fall;
   logic                   w_timeout;

   // Synchronizers rest at 1 (idle bus) so reset never fakes a falling edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         counter_q    <= '0;
         bit_count_q  <= '0;
         shift_q      <= '1;
         clk_drive_q  <= 1'b0;
         data_drive_q <= 1'b0;
         done_q       <= 1'b0;
         ack_ok_q     <= 1'b0;
         error_q      <= 1'b0;
         clk_s1_q     <= 1'b1;
         clk_s2_q     <= 1'b1;
         clk_prev_q   <= 1'b1;
         data_s1_q    <= 1'b1;
         data_s2_q    <= 1'b1;
      end else begin
         state_q      <= state_d;
         counter_q    <= counter_d;
         bit_count_q  <= bit_count_d;
         shift_q      <= shift_d;
         clk_drive_q  <= clk_drive_d;
         data_drive_q <= data_drive_d;
         done_q       <= done_d;
         ack_ok_q     <= ack_ok_d;
         error_q      <= error_d;
         clk_s1_q     <= clk_s1_d;
         clk_s2_q     <= clk_s2_d;
         clk_prev_q   <= clk_prev_d;
         data_s1_q    <= data_s1_d;
         data_s2_q    <= data_s2_d;
      end
   end

   always_comb begin
      clk_s1_d   = ps2ClkIn;
      clk_s2_d   = clk_s1_q;
      clk_prev_d = clk_s2_q;
      data_s1_d  = ps2DataIn;
      data_s2_d  = data_s1_q;
   end

   assign w_fall    = clk_prev_q & ~clk_s2_q;
   assign w_timeout = (counter_q == c_timeout_last);

   always_comb begin
      state_d      = state_q;
      counter_d    = counter_q;
      bit_count_d  = bit_count_q;
      shift_d      = shift_q;
      clk_drive_d  = clk_drive_q;
      data_drive_d = data_drive_q;
      done_d       = 1'b0;
      ack_ok_d     = ack_ok_q;
      error_d      = error_q;

      case (state_q)
         ST_IDLE: begin
            clk_drive_d  = 1'b0;
            data_drive_d = 1'b0;
            if (load) begin
               shift_d     = {1'b1, ~^data, data};
               ack_ok_d    = 1'b0;
               error_d     = 1'b0;
               counter_d   = '0;
               clk_drive_d = 1'b1;
               state_d     = ST_INHIBIT;
            end
         end

         ST_INHIBIT: begin
            if (counter_q == c_inhibit_last) begin
               counter_d    = '0;
               data_drive_d = 1'b1;
               state_d      = ST_RTS;
            end else begin
               counter_d = counter_q + 1'b1;
            end
         end

         ST_RTS: begin
            if (counter_q == c_rts_last) begin
               counter_d   = '0;
               clk_drive_d = 1'b0;
               bit_count_d = '0;
               state_d     = ST_SEND;
            end else begin
               counter_d = counter_q + 1'b1;
            end
         end

         ST_SEND, ST_WAIT_ACK, ST_WAIT_IDLE: begin
            counter_d = counter_q + 1'b1;
            // Timeout is checked before any clock edge so it takes priority.
            if (w_timeout) begin
               clk_drive_d  = 1'b0;
               data_drive_d = 1'b0;
               error_d      = 1'b1;
               ack_ok_d     = 1'b0;
               done_d       = 1'b1;
               counter_d    = '0;
               state_d      = ST_IDLE;
            end else if (state_q == ST_SEND) begin
               if (w_fall) begin
                  data_drive_d = ~shift_q[0];
                  shift_d      = {1'b1, shift_q[9:1]};
                  bit_count_d  = bit_count_q + 1'b1;
                  if (bit_count_q == 4'd9) begin
                     state_d = ST_WAIT_ACK;
                  end
               end
            end else if (state_q == ST_WAIT_ACK) begin
               if (w_fall) begin
                  ack_ok_d = ~data_s2_q;
                  error_d  = data_s2_q;
                  state_d  = ST_WAIT_IDLE;
               end
            end else begin
               if (clk_s2_q && data_s2_q) begin
                  done_d    = 1'b1;
                  counter_d = '0;
                  state_d   = ST_IDLE;
               end
            end
         end

         default: begin
            clk_drive_d  = 1'b0;
            data_drive_d = 1'b0;
            state_d      = ST_IDLE;
         end
      endcase
   end

   assign ps2ClkDriveLow  = clk_drive_q;
   assign ps2DataDriveLow = data_drive_q;
   assign busy            = (state_q != ST_IDLE);
   assign done            = done_q;
   assign ackOk           = ack_ok_q;
   assign error           = error_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_host_tx
//  Purpose  : Self-checking bench for ps2_host_tx with a simple device model.
//  Revision : 1.0
// ============================================================================
module tb_ps2_host_tx;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] tx_data;
   logic       load;
   logic       dev_clk;
   logic       dev_data;
   logic       ps2ClkDriveLow, ps2DataDriveLow, busy, done, ackOk, error;
   logic       line_clk, line_data;

   int n_checks = 0;
   int n_err    = 0;

   // Open-drain bus: either side can pull a line low.
   assign line_clk  = dev_clk  & ~ps2ClkDriveLow;
   assign line_data = dev_data & ~ps2DataDriveLow;

   always #5 clk = ~clk;

   ps2_host_tx dut (
      .clk            (clk),
      .reset          (reset),
      .data           (tx_data),
      .load           (load),
      .ps2ClkIn       (line_clk),
      .ps2DataIn      (line_data),
      .ps2ClkDriveLow (ps2ClkDriveLow),
      .ps2DataDriveLow(ps2DataDriveLow),
      .busy           (busy),
      .done           (done),
      .ackOk          (ackOk),
      .error          (error)
   );

   typedef struct {
      logic [7:0] d;
      logic       ack;
      int         inj;
      logic [7:0] exp_byte;
      logic       exp_par;
      logic       exp_ack_ok;
      logic       exp_err;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_load(input logic [7:0] d);
      @(negedge clk);
      tx_data = d;
      load    = 1'b1;
      @(negedge clk);
      load    = 1'b0;
   endtask

   task automatic run_transfer(input vec_t v);
      int         n_inh, n_rts, n, cnt;
      logic [9:0] bits;
      do_load(v.d);
      check("busy_after_load", busy, 1);
      n_inh = 0;
      while (ps2ClkDriveLow && !ps2DataDriveLow && n_inh < 2000) begin
         n_inh++;
         @(negedge clk);
      end
      n_rts = 0;
      while (ps2ClkDriveLow && ps2DataDriveLow && n_rts < 100) begin
         n_rts++;
         @(negedge clk);
      end
      check("inhibit_cycles", n_inh, 400);
      check("rts_cycles", n_rts, 4);
      check("start_bit_after_release", {ps2ClkDriveLow, ps2DataDriveLow}, 2'b01);
      repeat (10) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         dev_clk = 1'b0;
         if (i == v.inj) begin
            tx_data = 8'h3C;
            load    = 1'b1;
            @(negedge clk);
            load    = 1'b0;
            repeat (14) @(negedge clk);
         end else begin
            repeat (15) @(negedge clk);
         end
         bits[i] = line_data;
         dev_clk = 1'b1;
         repeat (15) @(negedge clk);
      end
      check("rx_byte", bits[7:0], v.exp_byte);
      check("rx_parity", bits[8], v.exp_par);
      check("rx_stop", bits[9], 1);
      dev_data = ~v.ack;
      repeat (5) @(negedge clk);
      dev_clk = 1'b0;
      repeat (15) @(negedge clk);
      dev_clk  = 1'b1;
      dev_data = 1'b1;
      n = 0;
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", done, 1);
      check("busy_at_done", busy, 0);
      check("ack_ok", ackOk, v.exp_ack_ok);
      check("error", error, v.exp_err);
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) cnt++;
      end
      check("done_extra_pulses", cnt, 0);
      check("ack_ok_held", ackOk, v.exp_ack_ok);
   endtask

   initial begin
      int   n, cnt;
      vec_t v;
      vecs[0] = '{8'hED, 1'b1, -1, 8'hED, 1'b1, 1'b1, 1'b0};
      vecs[1] = '{8'h00, 1'b1, -1, 8'h00, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{8'hFF, 1'b1, -1, 8'hFF, 1'b1, 1'b1, 1'b0};
      vecs[3] = '{8'h01, 1'b1, -1, 8'h01, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{8'h5A, 1'b0, -1, 8'h5A, 1'b1, 1'b0, 1'b1};
      vecs[5] = '{8'hA5, 1'b1,  3, 8'hA5, 1'b1, 1'b1, 1'b0};

      reset    = 1'b1;
      load     = 1'b0;
      tx_data  = 8'h00;
      dev_clk  = 1'b1;
      dev_data = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset_outputs",
            {ps2ClkDriveLow, ps2DataDriveLow, busy, done, ackOk, error}, 6'b0);

      for (int k = 0; k < 6; k++) begin
         run_transfer(vecs[k]);
      end

      // Device never clocks: the transfer must time out.
      do_load(8'h42);
      n = 0;
      while (ps2ClkDriveLow && n < 1000) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (!done && n < 70000) begin
         @(negedge clk);
         n++;
      end
      check("timeout_done", done, 1);
      check("timeout_window", (n >= 59998 && n <= 60002), 1);
      check("timeout_drives", {ps2ClkDriveLow, ps2DataDriveLow}, 2'b00);
      check("timeout_flags", {busy, ackOk, error}, 3'b001);
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) cnt++;
      end
      check("timeout_done_once", cnt, 0);

      // Reset in the middle of SEND.
      do_load(8'h77);
      n = 0;
      while (ps2ClkDriveLow && n < 1000) begin
         @(negedge clk);
         n++;
      end
      repeat (10) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         dev_clk = 1'b0;
         repeat (15) @(negedge clk);
         dev_clk = 1'b1;
         repeat (15) @(negedge clk);
      end
      check("busy_before_reset", busy, 1);
      dev_clk = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("reset_mid_send",
            {ps2ClkDriveLow, ps2DataDriveLow, busy, done, ackOk, error}, 6'b0);
      reset   = 1'b0;
      dev_clk = 1'b1;
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) cnt++;
      end
      check("no_done_after_reset", cnt, 0);

      v = '{8'hFF, 1'b1, -1, 8'hFF, 1'b1, 1'b1, 1'b0};
      run_transfer(v);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
